conv_frame_ctrl: RTL and testbench

Frame sequencer for the 3x3 `conv` streaming engine. Holds the nine kernel weights behind a small config write port. On `start`, it resets the engine, streams one IMG_N x IMG_N frame from a 1-cycle-latency pixel memory into the engine, and flushes the engine pipeline. It writes the (IMG_N-2)^2 valid results row-major into a result memory, then pulses `done`.

---
 rtl/conv_frame_ctrl_if.sv | 39 +++
 rtl/conv_frame_ctrl.sv | 129 ++++++++++++
 tb/tb_conv_frame_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_frame_ctrl_if.sv
// Signal bundle between the frame sequencer and its environment: control,
// kernel config, pixel memory, conv engine and result memory.
interface conv_frame_ctrl_if #(
  parameter int N   = 16,
  parameter int PAW = 6,
  parameter int RAW = 4
);
  logic           start;
  logic           busy;
  logic           done;
  logic           cfg_we;
  logic [3:0]     cfg_addr;
  logic [N-1:0]   cfg_wdata;
  logic           cfg_err;
  logic [N-1:0]   k00, k01, k02, k10, k11, k12, k20, k21, k22;
  logic           pix_re;
  logic [PAW-1:0] pix_addr;
  logic [N-1:0]   pix_rdata;
  logic           eng_rst;
  logic           eng_en;
  logic [N-1:0]   eng_pixel;
  logic [N-1:0]   eng_conv_out;
  logic           eng_out_valid;
  logic           res_we;
  logic [RAW-1:0] res_addr;
  logic [N-1:0]   res_data;

  modport master (
    input  start, cfg_we, cfg_addr, cfg_wdata, pix_rdata, eng_conv_out, eng_out_valid,
    output busy, done, cfg_err, k00, k01, k02, k10, k11, k12, k20, k21, k22,
           pix_re, pix_addr, eng_rst, eng_en, eng_pixel, res_we, res_addr, res_data
  );

  modport slave (
    output start, cfg_we, cfg_addr, cfg_wdata, pix_rdata, eng_conv_out, eng_out_valid,
    input  busy, done, cfg_err, k00, k01, k02, k10, k11, k12, k20, k21, k22,
           pix_re, pix_addr, eng_rst, eng_en, eng_pixel, res_we, res_addr, res_data
  );
endinterface

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the 3x3 conv engine: holds kernel weights, streams one
// IMG_N x IMG_N frame through the engine and captures the valid results.
module conv_frame_ctrl #(
  parameter int N     = 16,
  parameter int IMG_N = 6,
  parameter int PAW   = 6,
  parameter int RAW   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  conv_frame_ctrl_if.master  bus
);
  localparam int PIX_LAST = IMG_N * IMG_N - 1;
  localparam int RES_LAST = (IMG_N - 2) * (IMG_N - 2) - 1;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [PAW-1:0]   r_pix_cnt;
  logic [RAW-1:0]   r_res_cnt;
  logic [RAW-1:0]   r_res_addr;
  logic [N-1:0]     r_res_data;
  logic             r_res_we;
  logic             r_rd_valid;
  logic             r_flush;
  logic             r_cfg_err;
  logic [8:0][N-1:0] r_kern;

  logic w_busy, w_done, w_pix_re, w_eng_rst;
  logic w_last_pix, w_last_res, w_capture;

  assign w_last_pix = (r_pix_cnt == PAW'(PIX_LAST));
  assign w_last_res = r_res_we && (r_res_addr == RAW'(RES_LAST));
  assign w_capture  = bus.eng_out_valid && ((r_state == S_STREAM) || (r_state == S_DRAIN));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next    = r_state;
    w_busy    = 1'b1;
    w_done    = 1'b0;
    w_pix_re  = 1'b0;
    w_eng_rst = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy    = 1'b0;
        w_eng_rst = 1'b1;
        if (bus.start) w_next = S_CLEAR;
      end
      S_CLEAR: begin
        w_eng_rst = 1'b1;
        w_next    = S_STREAM;
      end
      S_STREAM: begin
        w_pix_re = 1'b1;
        if (w_last_pix) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_last_res) w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: the kernel store is nine plain flops, not a RAM, so it is reset with the rest.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pix_cnt  <= '0;
      r_res_cnt  <= '0;
      r_res_addr <= '0;
      r_res_data <= '0;
      r_res_we   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_flush    <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_kern     <= '0;
    end else begin
      r_rd_valid <= w_pix_re;
      // One zero-pixel enable after the last real pixel lets the engine register the final window.
      r_flush    <= (r_state == S_DRAIN) && r_rd_valid;
      r_cfg_err  <= bus.cfg_we && w_busy;
      if (bus.cfg_we && !w_busy && (bus.cfg_addr <= 4'd8))
        r_kern[bus.cfg_addr] <= bus.cfg_wdata;

      if (r_state == S_CLEAR)        r_pix_cnt <= '0;
      else if (w_pix_re && !w_last_pix) r_pix_cnt <= r_pix_cnt + PAW'(1);

      if (r_state == S_CLEAR) r_res_cnt <= '0;
      else if (w_capture)     r_res_cnt <= r_res_cnt + RAW'(1);

      r_res_we <= w_capture;
      if (w_capture) begin
        r_res_data <= bus.eng_conv_out;
        r_res_addr <= r_res_cnt;
      end
    end
  end

  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.cfg_err   = r_cfg_err;
  assign bus.k00       = r_kern[0];
  assign bus.k01       = r_kern[1];
  assign bus.k02       = r_kern[2];
  assign bus.k10       = r_kern[3];
  assign bus.k11       = r_kern[4];
  assign bus.k12       = r_kern[5];
  assign bus.k20       = r_kern[6];
  assign bus.k21       = r_kern[7];
  assign bus.k22       = r_kern[8];
  assign bus.pix_re    = w_pix_re;
  assign bus.pix_addr  = r_pix_cnt;
  assign bus.eng_rst   = w_eng_rst;
  assign bus.eng_en    = r_rd_valid | r_flush;
  assign bus.eng_pixel = r_rd_valid ? bus.pix_rdata : '0;
  assign bus.res_we    = r_res_we;
  assign bus.res_addr  = r_res_addr;
  assign bus.res_data  = r_res_data;
endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Bench for conv_frame_ctrl: pixel memory and 3x3 engine models, a result
// scoreboard, table-driven frames plus config/reset corner sequences.
module tb_conv_frame_ctrl;
  localparam int N     = 16;
  localparam int IMG_N = 6;
  localparam int PAW   = 6;
  localparam int RAW   = 4;
  localparam int NPIX  = IMG_N * IMG_N;
  localparam int NRES  = (IMG_N - 2) * (IMG_N - 2);
  localparam int RW    = IMG_N - 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_frame_ctrl_if #(.N(N), .PAW(PAW), .RAW(RAW)) bus ();

  conv_frame_ctrl #(.N(N), .IMG_N(IMG_N), .PAW(PAW), .RAW(RAW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bench-side copies of what the memories and kernel should hold
  logic [N-1:0]      g_mem [NPIX];
  logic [8:0][N-1:0] g_kern;
  logic [8:0][N-1:0] dut_k;
  assign dut_k = {bus.k22, bus.k21, bus.k20, bus.k12, bus.k11, bus.k10, bus.k02, bus.k01, bus.k00};

  always @(posedge clk) if (bus.pix_re) bus.pix_rdata <= g_mem[bus.pix_addr];

  // Engine model: window formed on the pixel's enable edge, output on the next enabled edge
  logic [N-1:0] e_img [NPIX];
  int           e_cnt = 0;
  logic         e_v1  = 1'b0;
  logic [N-1:0] e_s1  = '0;

  function automatic logic [N-1:0] eng_sum(input int p, input logic [N-1:0] cur);
    int acc = 0;
    int r = p / IMG_N;
    int c = p % IMG_N;
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++) begin
        int q = (r - 2 + a) * IMG_N + (c - 2 + b);
        logic [N-1:0] pv = (q == p) ? cur : e_img[q];
        acc += $signed(dut_k[3*a+b]) * $signed(pv);
      end
    return acc[N-1:0];
  endfunction

  function automatic logic pos_ok(input int p);
    return ((p / IMG_N) >= 2) && ((p % IMG_N) >= 2);
  endfunction

  always @(posedge clk) begin
    if (bus.eng_rst) begin
      e_cnt             <= 0;
      e_v1              <= 1'b0;
      e_s1              <= '0;
      bus.eng_out_valid <= 1'b0;
      bus.eng_conv_out  <= '0;
    end else if (bus.eng_en) begin
      bus.eng_out_valid <= e_v1;
      bus.eng_conv_out  <= e_s1;
      if (e_cnt < NPIX) begin
        e_img[e_cnt] <= bus.eng_pixel;
        e_v1         <= pos_ok(e_cnt);
        e_s1         <= eng_sum(e_cnt, bus.eng_pixel);
        e_cnt        <= e_cnt + 1;
      end else begin
        e_v1 <= 1'b0;
      end
    end else begin
      bus.eng_out_valid <= 1'b0;
    end
  end

  // Scoreboard of expected result writes, with the cycle (relative to start) each must appear in
  typedef struct {
    int           addr;
    logic [N-1:0] data;
    int           cyc;
  } res_t;
  res_t sb[$];

  int           wr_cnt   = 0;
  int           done_cnt = 0;
  logic [N-1:0] first_d  = '0;
  logic [N-1:0] last_d   = '0;

  always @(negedge clk) begin
    if (rst_n && bus.res_we) begin
      if (sb.size() == 0) begin
        check("res_extra", sb.size(), 1);
      end else begin
        check("res_addr", bus.res_addr, sb[0].addr);
        check("res_data", bus.res_data, sb[0].data);
        check("res_cycle", cyc - t0, sb[0].cyc);
        sb.delete(0);
      end
      if (wr_cnt == 0 || (cyc - t0) < 21) first_d <= bus.res_data;
      last_d <= bus.res_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.done) done_cnt <= done_cnt + 1;
  end

  function automatic logic [N-1:0] exp_res(input int idx);
    int acc = 0;
    int i = idx / RW;
    int j = idx % RW;
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++)
        acc += $signed(g_kern[3*a+b]) * $signed(g_mem[(i + a) * IMG_N + j + b]);
    return acc[N-1:0];
  endfunction

  task automatic check_k(input string tag);
    for (int i = 0; i < 9; i++) check($sformatf("%s_k%0d", tag, i), dut_k[i], g_kern[i]);
  endtask

  // Entered and left at posedge+1 while the DUT is idle
  task automatic write_cfg(input logic [3:0] addr, input logic [N-1:0] data);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = addr;
    bus.cfg_wdata = data;
    if (addr <= 4'd8) g_kern[addr] = data;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    @(negedge clk);
    check("cfg_err_idle", bus.cfg_err, 0);
    @(posedge clk); #1;
  endtask

  task automatic load_kernel(input logic [8:0][N-1:0] k);
    for (int i = 0; i < 9; i++) write_cfg(4'(i), k[i]);
  endtask

  task automatic load_mem(input int mul, input int add);
    for (int a = 0; a < NPIX; a++) g_mem[a] = N'(mul * a + add);
  endtask

  // One frame with start in cycle 0; optional cfg write (+start) in inj_cyc, optional reset in rst_cyc
  task automatic run_frame(input int inj_cyc, input logic [3:0] inj_addr,
                           input logic [N-1:0] inj_data, input int rst_cyc);
    int prof_err = 0;
    int done_cyc = -1;
    int wr_base  = wr_cnt;
    int dn_base  = done_cnt;
    int last_n   = (rst_cyc >= 0) ? rst_cyc + 2 : 45;
    if (inj_cyc == 0 && inj_addr <= 4'd8) g_kern[inj_addr] = inj_data;
    for (int idx = 0; idx < NRES; idx++) begin
      res_t e;
      e.addr = idx;
      e.data = exp_res(idx);
      e.cyc  = ((idx / RW) + 2) * IMG_N + (idx % RW) + 2 + 6;
      sb.push_back(e);
    end
    t0            = cyc;
    bus.start     = 1'b1;
    bus.cfg_we    = (inj_cyc == 0);
    bus.cfg_addr  = inj_addr;
    bus.cfg_wdata = inj_data;
    for (int n = 0; n <= last_n; n++) begin
      @(negedge clk);
      if (rst_cyc < 0 || n <= rst_cyc) begin
        if (bus.busy    !== (n >= 1 && n <= 42))                 prof_err++;
        if (bus.eng_en  !== (n >= 3 && n <= 39))                 prof_err++;
        if (bus.eng_rst !== !(n >= 2 && n <= 42))                prof_err++;
        if (bus.pix_re  !== (n >= 2 && n <= 37))                 prof_err++;
        if (bus.done    !== (n == 42))                           prof_err++;
        if (bus.cfg_err !== (inj_cyc > 0 && n == inj_cyc + 1))   prof_err++;
        if (n >= 2 && n <= 37 && bus.pix_addr !== PAW'(n - 2))   prof_err++;
        if (n == 39 && bus.eng_pixel !== '0)                     prof_err++;
      end
      if (bus.done) done_cyc = n;
      if (inj_cyc > 0 && n == inj_cyc + 1) check("cfg_err_busy", bus.cfg_err, 1);
      if (rst_cyc >= 0 && n == rst_cyc + 1) begin
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_cfg_err", bus.cfg_err, 0);
        check("rst_pix_re", bus.pix_re, 0);
        check("rst_pix_addr", bus.pix_addr, 0);
        check("rst_eng_rst", bus.eng_rst, 1);
        check("rst_eng_en", bus.eng_en, 0);
        check("rst_eng_pixel", bus.eng_pixel, 0);
        check("rst_res_we", bus.res_we, 0);
        check("rst_res_addr", bus.res_addr, 0);
        check("rst_res_data", bus.res_data, 0);
      end
      @(posedge clk); #1;
      bus.start  = (inj_cyc > 0 && n + 1 == inj_cyc);
      bus.cfg_we = (inj_cyc > 0 && n + 1 == inj_cyc);
      rst_n      = !(rst_cyc >= 0 && n + 1 == rst_cyc);
    end
    bus.start  = 1'b0;
    bus.cfg_we = 1'b0;
    rst_n      = 1'b1;
    check("profile", prof_err, 0);
    if (rst_cyc < 0) begin
      check("done_count", done_cnt - dn_base, 1);
      check("done_cycle", done_cyc, 42);
      check("write_count", wr_cnt - wr_base, NRES);
      check("sb_empty", sb.size(), 0);
    end else begin
      check("done_after_rst", done_cnt - dn_base, 0);
      check("partial_writes", wr_cnt - wr_base, 4);
      check("sb_left", sb.size(), NRES - 4);
      sb.delete();
    end
  endtask

  typedef struct {
    logic [8:0][N-1:0] kern;
    int                pix_mul;
    int                pix_add;
    logic [N-1:0]      exp_first;
    logic [N-1:0]      exp_last;
  } vec_t;

  vec_t vecs[4];
  logic [8:0][N-1:0] ident;

  initial begin
    ident    = '0;
    ident[4] = 16'd1;
    vecs[0] = '{kern: ident,            pix_mul: 1, pix_add: 0, exp_first: 16'd7,    exp_last: 16'd28};
    vecs[1] = '{kern: {9{16'd1}},       pix_mul: 0, pix_add: 1, exp_first: 16'd9,    exp_last: 16'd9};
    vecs[2] = '{kern: {9{16'h7FFF}},    pix_mul: 0, pix_add: 2, exp_first: 16'hFFEE, exp_last: 16'hFFEE};
    vecs[3] = '{kern: '0,               pix_mul: 1, pix_add: 0, exp_first: 16'h01AD, exp_last: 16'h055E};
    for (int i = 0; i < 9; i++) vecs[3].kern[i] = N'(i + 1);

    g_kern        = '0;
    bus.start     = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_wdata = '0;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("init_busy", bus.busy, 0);
    check("init_done", bus.done, 0);
    check("init_eng_rst", bus.eng_rst, 1);
    check("init_eng_en", bus.eng_en, 0);
    check("init_pix_re", bus.pix_re, 0);
    check("init_res_we", bus.res_we, 0);
    check_k("init");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 4; v++) begin
      load_kernel(vecs[v].kern);
      load_mem(vecs[v].pix_mul, vecs[v].pix_add);
      run_frame(-1, 4'd0, '0, -1);
      check($sformatf("vec%0d_first", v), first_d, vecs[v].exp_first);
      check($sformatf("vec%0d_last", v), last_d, vecs[v].exp_last);
    end

    // Out-of-range address in IDLE: no kernel change, no error
    load_kernel(ident);
    write_cfg(4'd9, 16'h1234);
    check_k("addr9");

    // Write to k00 in the start cycle is used by that frame
    load_mem(1, 0);
    run_frame(0, 4'd0, 16'd2, -1);
    check("k00_same_cycle_last", last_d, 16'd70);
    check_k("k00_same_cycle");

    // Write and start while streaming: write dropped, error pulse, start ignored
    write_cfg(4'd0, 16'd0);
    run_frame(10, 4'd4, 16'd5, -1);
    check("k11_kept", bus.k11, 16'd1);
    check("ident_last", last_d, 16'd28);

    // Reset mid-frame, then a fresh identity frame
    run_frame(-1, 4'd0, '0, 25);
    g_kern = '0;
    check_k("after_rst");
    load_kernel(ident);
    run_frame(-1, 4'd0, '0, -1);
    check("post_rst_first", first_d, 16'd7);
    check("post_rst_last", last_d, 16'd28);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
